// File: rtl/pulse_period_meter.sv
// Measures the rising-edge-to-rising-edge period of pulse_in in clk cycles,
// flags lock when consecutive periods sit within TOLERANCE of FREQ_CLK.
//
// state   | meaning
// IDLE    | no reference edge yet (after reset or timeout)
// MEASURE | counting cycles since the last rising edge
module pulse_period_meter #(
    parameter int FREQ_CLK   = 50000000,
    parameter int TOLERANCE  = 1000,
    parameter int LOCK_COUNT = 3,
    parameter int SYNC       = 1,
    localparam int MAX_CNT   = 2 * FREQ_CLK,
    localparam int W         = $clog2(MAX_CNT + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pulse_in,
    output logic [W-1:0] period,
    output logic         period_valid,
    output logic         locked,
    output logic         timeout
);

    localparam int WX = W + 1;
    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam logic [W-1:0]  CNT_MAX  = W'(MAX_CNT);
    localparam logic [WX-1:0] TOL_LO   = WX'(FREQ_CLK - TOLERANCE);
    localparam logic [WX-1:0] TOL_HI   = WX'(FREQ_CLK + TOLERANCE);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_COUNT);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]  period_d;
    logic          period_valid_d, locked_d, timeout_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d, lock_inc;
    logic          pin, pin_q, pin_rise, in_tol;

    generate
        if (SYNC != 0) begin : g_sync
            logic sync1, sync2;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync1 <= 1'b0;
                    sync2 <= 1'b0;
                end else begin
                    sync1 <= pulse_in;
                    sync2 <= sync1;
                end
            end
            assign pin = sync2;
        end else begin : g_nosync
            assign pin = pulse_in;
        end
    endgenerate

    assign pin_rise = pin & ~pin_q;

    // Widened by one bit so FREQ_CLK+TOLERANCE can never wrap
    assign in_tol   = ({1'b0, cnt_q} >= TOL_LO) && ({1'b0, cnt_q} <= TOL_HI);
    assign lock_inc = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + LW'(1);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        period_d       = period;
        period_valid_d = 1'b0;
        locked_d       = locked;
        timeout_d      = timeout;
        lock_cnt_d     = lock_cnt_q;
        case (state_q)
            IDLE: begin
                if (pin_rise) begin
                    cnt_d     = W'(1);
                    state_d   = MEASURE;
                    timeout_d = 1'b0;
                end
            end
            MEASURE: begin
                // An edge on the saturation cycle still counts as a valid period
                if (pin_rise) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    cnt_d          = W'(1);
                    if (in_tol) begin
                        lock_cnt_d = lock_inc;
                        locked_d   = (lock_inc == LOCK_MAX);
                    end else begin
                        lock_cnt_d = '0;
                        locked_d   = 1'b0;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d    = IDLE;
                    timeout_d  = 1'b1;
                    locked_d   = 1'b0;
                    lock_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pin_q        <= 1'b0;
            lock_cnt_q   <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pin_q        <= pin;
            lock_cnt_q   <= lock_cnt_d;
            period       <= period_d;
            period_valid <= period_valid_d;
            locked       <= locked_d;
            timeout      <= timeout_d;
        end
    end

endmodule
